timer_bcd_countdown: RTL
========================

# timer_bcd_countdown

Minutes:seconds BCD countdown timer for the timer-entry/control path. It is fed digit-by-digit from the keypad stage and is armed by the entry-settle flag from the upstream non-recycling delay counter. The block counts down once per second, derived from an internal prescaler, and reports completion to the control FSM and the display driver.

## Interface
- CLK_PER_SEC, default 50_000_000: clk cycles per one-second decrement; must be ≥ 2.
- clk  input  1  system clock; all state changes on its rising edge.
- clear  input  1  asynchronous, active-high reset.
- arm  input  1  level; entry-settle flag from the upstream stage; start is ignored while low.
- load  input  1  one-cycle pulse; shifts data_in into the digit register.
- data_in  input  4  BCD key digit; values 10–15 are ignored.
- start  input  1  one-cycle pulse; begin or resume the countdown.
- stop  input  1  one-cycle pulse; pause, or abort to IDLE.
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  current BCD value, registered.
- running  output  1  high in RUN.
- done  output  1  high in DONE.

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - PAUSE
  - DONE
- Reset: all digits 0, prescaler 0, state IDLE, running 0, done 0.
- Digit entry applies in IDLE and PAUSE when load=1 and data_in ≤ 9.
  - Left shift: min_tens←min_ones, min_ones←sec_tens, sec_tens←sec_ones, sec_ones←data_in.
  - The old min_tens is discarded.
  - load is ignored in RUN.
- IDLE→RUN: start=1, arm=1, value ≠ 00:00. Prescaler is cleared to 0.
- IDLE: start with value 00:00, or with arm=0, is ignored.
- RUN: prescaler increments each cycle. When it reaches CLK_PER_SEC-1 it wraps to 0 and the value decrements by one second.
- Decrement rules:
  - sec_ones>0: sec_ones−1.
  - Otherwise, sec_tens>0: sec_tens−1, sec_ones=9.
  - Otherwise, min_ones>0: min_ones−1, sec=59.
  - Otherwise: min_tens−1, min_ones=9, sec=59.
- Seconds entered above 59 (e.g. 00:75) are not normalised. They count down literally, 75, 74, … until the seconds reach 00, then borrow.
- RUN→DONE: the decrement that produces 00:00 moves to DONE in the same edge.
- RUN→PAUSE: on stop=1. The prescaler value is held.
- PAUSE→RUN: on start=1 and arm=1. The prescaler resumes from its held value and is not cleared.
- PAUSE→IDLE: on a second stop=1. Digits are cleared to 00:00.
- DONE→IDLE: on stop=1 or load=1. Digits are cleared. A load's digit (if valid) is shifted into the cleared register on the same edge.
- DONE: start is ignored.
- Simultaneous start and stop in any state: stop wins.
- Simultaneous load and start in IDLE/PAUSE: load is applied and start is ignored that cycle.
- arm falling during RUN has no effect. arm gates only start acceptance.
- clear asserted mid-countdown returns immediately to the reset values, regardless of state.

## Timing
- All outputs are registered. running and done change on the same edge as the state.
- Start accepted at edge N: running=1 after edge N. The first decrement is visible after edge N+CLK_PER_SEC.
- A value V seconds (V ≥ 1) reaches DONE exactly V·CLK_PER_SEC cycles after start, excluding paused cycles.
- load at edge N: the new digit is visible after edge N; one digit is shifted per pulse.
- Pause and resume preserve the sub-second phase, with no lost or extra cycles.

## Structure
- Shared package (timer_pkg), owned jointly with the control FSM:
  - state enum (IDLE, RUN, PAUSE, DONE)
  - BCD digit typedef (4-bit)
  - BCD_MAX=9 and SEC_TENS_ROLL=5
- Sub-module bcd_time_dec: combinational 4-digit BCD decrement with borrow, per the decrement rules. It is also reused by the display blink logic.
- Prescaler and FSM stay in the top module.

## Test plan
- Parameter CLK_PER_SEC=4 throughout.
- Entry and start: clear, then load 0,1,0,5. Expect 01:05. start with arm=1 → running=1. After 4 cycles expect 01:04.
- Minute borrow and completion: start from 01:00 → 00:59 after 4 cycles. done=1 exactly 240 cycles after start; digits 00:00; running=0.
- Pause phase: start 00:03, stop after 6 cycles (value 00:02, prescaler 2), wait 20 cycles with value unchanged. start → 00:01 after exactly 2 more cycles.
- Ignored inputs:
  - start with arm=0 → stays IDLE.
  - start at 00:00 → stays IDLE.
  - load data_in=12 → digits unchanged.
  - load during RUN → digits unchanged.
  - start+stop in the same cycle during RUN → PAUSE.
- DONE exit: in DONE, load 7 → IDLE with 00:07, done=0. A second stop from PAUSE → IDLE with 00:00.
- Async clear: assert clear mid-cycle (between edges) during RUN at 00:30. Outputs are 00:00 with running=0 before the next edge. Normal entry works after release.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer and its control FSM.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX       = 4'd9;
  localparam bcd_t SEC_TENS_ROLL = 4'd5;

endpackage

// File: rtl/bcd_time_dec.sv
// Combinational one-second decrement of an MM:SS BCD value with borrow.
// Seconds above 59 are decremented literally; borrows reload seconds to 59.
module bcd_time_dec
  import timer_pkg::*;
(
  input  bcd_t min_tens,
  input  bcd_t min_ones,
  input  bcd_t sec_tens,
  input  bcd_t sec_ones,
  output bcd_t nxt_min_tens,
  output bcd_t nxt_min_ones,
  output bcd_t nxt_sec_tens,
  output bcd_t nxt_sec_ones,
  output logic nxt_zero
);

  always_comb begin
    nxt_min_tens = min_tens;
    nxt_min_ones = min_ones;
    nxt_sec_tens = sec_tens;
    nxt_sec_ones = sec_ones;
    if (sec_ones != 4'd0) begin
      nxt_sec_ones = sec_ones - 4'd1;
    end else if (sec_tens != 4'd0) begin
      nxt_sec_tens = sec_tens - 4'd1;
      nxt_sec_ones = BCD_MAX;
    end else if (min_ones != 4'd0) begin
      nxt_min_ones = min_ones - 4'd1;
      nxt_sec_tens = SEC_TENS_ROLL;
      nxt_sec_ones = BCD_MAX;
    end else begin
      nxt_min_tens = min_tens - 4'd1;
      nxt_min_ones = BCD_MAX;
      nxt_sec_tens = SEC_TENS_ROLL;
      nxt_sec_ones = BCD_MAX;
    end
  end

  assign nxt_zero = (nxt_min_tens == 4'd0) && (nxt_min_ones == 4'd0) &&
                    (nxt_sec_tens == 4'd0) && (nxt_sec_ones == 4'd0);

endmodule

// File: rtl/timer_bcd_countdown.sv
// MM:SS BCD countdown timer: keypad digit entry, one-second prescaler and
// IDLE/RUN/PAUSE/DONE control with registered status outputs.
module timer_bcd_countdown
  import timer_pkg::*;
#(
  parameter int CLK_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       arm,
  input  logic       load,
  input  logic [3:0] data_in,
  input  logic       start,
  input  logic       stop,
  output bcd_t       min_tens,
  output bcd_t       min_ones,
  output bcd_t       sec_tens,
  output bcd_t       sec_ones,
  output logic       running,
  output logic       done
);

  localparam int PW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);

  state_t        state;
  logic [PW-1:0] presc;

  bcd_t dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones;
  logic dec_zero;
  logic digit_ok;
  logic value_zero;

  bcd_time_dec u_dec (
    .min_tens     (min_tens),
    .min_ones     (min_ones),
    .sec_tens     (sec_tens),
    .sec_ones     (sec_ones),
    .nxt_min_tens (dec_min_tens),
    .nxt_min_ones (dec_min_ones),
    .nxt_sec_tens (dec_sec_tens),
    .nxt_sec_ones (dec_sec_ones),
    .nxt_zero     (dec_zero)
  );

  assign digit_ok   = (data_in <= BCD_MAX);
  assign value_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd0);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= ST_IDLE;
      presc    <= '0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A load pulse in the same cycle masks start
          if (load) begin
            if (digit_ok) begin
              min_tens <= min_ones;
              min_ones <= sec_tens;
              sec_tens <= sec_ones;
              sec_ones <= data_in;
            end
          end else if (start && !stop && arm && !value_zero) begin
            state   <= ST_RUN;
            presc   <= '0;
            running <= 1'b1;
          end
        end

        ST_RUN: begin
          if (stop) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end else if (presc == PRESC_LAST) begin
            presc    <= '0;
            min_tens <= dec_min_tens;
            min_ones <= dec_min_ones;
            sec_tens <= dec_sec_tens;
            sec_ones <= dec_sec_ones;
            if (dec_zero) begin
              state   <= ST_DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end

        ST_PAUSE: begin
          // Prescaler is left untouched so a resume keeps the sub-second phase
          if (stop) begin
            state    <= ST_IDLE;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end else if (load) begin
            if (digit_ok) begin
              min_tens <= min_ones;
              min_ones <= sec_tens;
              sec_tens <= sec_ones;
              sec_ones <= data_in;
            end
          end else if (start && arm && !value_zero) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end

        ST_DONE: begin
          if (stop || load) begin
            state    <= ST_IDLE;
            done     <= 1'b0;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= (load && digit_ok) ? data_in : 4'd0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
